// File: rtl/miner_pkg.sv
// Shared constants and types for the hash miner: widths, round constants and FSM encodings.
package miner_pkg;
    localparam int HASH_W      = 8;
    localparam int DATA_W      = 48;
    localparam int HASH_ROUNDS = 6;
    localparam int ROT_AMT     = 3;

    typedef logic [HASH_W-1:0] hash_t;

    localparam hash_t ROUND_CONST = 8'h5A;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/hash_miner_if.sv
// Controller <-> miner bundle: load strobes, block/prev data, enable level and result outputs.
interface hash_miner_if
    import miner_pkg::*;
#(
    parameter int NONCE_W = 8
);
    logic                 load_registers;
    logic [DATA_W-1:0]    block_data;
    logic                 load_previous_hash;
    hash_t                prev_hash_in;
    logic                 enable_mining;
    hash_t                mining_hash;
    logic                 done_mining;
    logic                 mining_failed;
    logic [NONCE_W-1:0]   nonce;
    logic                 busy;

    modport master (
        output load_registers, block_data, load_previous_hash, prev_hash_in, enable_mining,
        input  mining_hash, done_mining, mining_failed, nonce, busy
    );

    modport slave (
        input  load_registers, block_data, load_previous_hash, prev_hash_in, enable_mining,
        output mining_hash, done_mining, mining_failed, nonce, busy
    );
endinterface

// File: rtl/hash_round.sv
// One combinational mixing round: rotate left, xor in a data byte, add the round constant.
module hash_round
    import miner_pkg::*;
(
    input  hash_t h_i,
    input  hash_t byte_i,
    output hash_t h_o
);
    hash_t rot;

    assign rot = {h_i[HASH_W-1-ROT_AMT:0], h_i[HASH_W-1:HASH_W-ROT_AMT]};
    assign h_o = (rot ^ byte_i) + ROUND_CONST;
endmodule

// File: rtl/hash_miner.sv
// Nonce-search mining engine; one hash round per cycle, leading-zero difficulty test.
// Build option MINER_ATTEMPT_LIMIT_EN: also stop a failing search after MAX_ATTEMPTS attempts.
//   state | meaning
//   IDLE  | loads accepted, waiting for enable_mining
//   ROUND | applying rounds 0..5 to the current nonce's hash
//   CHECK | difficulty test, then finish or advance nonce
//   DONE  | result held until enable_mining drops
module hash_miner
    import miner_pkg::*;
#(
    parameter int DIFFICULTY   = 2,
    parameter int NONCE_W      = 8,
    parameter int MAX_ATTEMPTS = 16
) (
    input  logic          clock,
    input  logic          resetn,
    hash_miner_if.slave   bus
);
    if (DIFFICULTY < 0 || DIFFICULTY > HASH_W) begin : g_bad_diff
        $error("hash_miner: DIFFICULTY out of range");
    end
    if (NONCE_W < 1 || NONCE_W > HASH_W) begin : g_bad_nonce
        $error("hash_miner: NONCE_W out of range");
    end
    if (MAX_ATTEMPTS < 1) begin : g_bad_max
        $error("hash_miner: MAX_ATTEMPTS must be positive");
    end

    // Top DIFFICULTY bits must be zero; a zero mask makes every hash pass.
    localparam hash_t PASS_MASK = ~(8'hFF >> DIFFICULTY);

    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    hash_t               prev_q, prev_d;
    hash_t               h_q, h_d;
    hash_t               hash_q, hash_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;
    logic [2:0]          rcnt_q, rcnt_d;
    logic                done_q, done_d;
    logic                failed_q, failed_d;

    hash_t               round_byte;
    hash_t               round_out;
    logic [NONCE_W-1:0]  nonce_inc;
    logic                pass;
    logic                last_try;

    assign round_byte = data_q[DATA_W-1-HASH_W*int'(rcnt_q) -: HASH_W];
    assign nonce_inc  = nonce_q + NONCE_W'(1);
    assign pass       = ((h_q & PASS_MASK) == '0);

`ifdef MINER_ATTEMPT_LIMIT_EN
    assign last_try = (nonce_q == {NONCE_W{1'b1}}) ||
                      (32'(nonce_q) == 32'(MAX_ATTEMPTS - 1));
`else
    assign last_try = (nonce_q == {NONCE_W{1'b1}});
`endif

    hash_round u_round (
        .h_i    (h_q),
        .byte_i (round_byte),
        .h_o    (round_out)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        prev_d   = prev_q;
        h_d      = h_q;
        hash_d   = hash_q;
        nonce_d  = nonce_q;
        rcnt_d   = rcnt_q;
        done_d   = done_q;
        failed_d = failed_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_registers)     data_d = bus.block_data;
                if (bus.load_previous_hash) prev_d = bus.prev_hash_in;
                // Seed from prev_d so a same-cycle load feeds this search.
                if (bus.enable_mining) begin
                    nonce_d = '0;
                    h_d     = prev_d;
                    rcnt_d  = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (!bus.enable_mining) begin
                    state_d = ST_IDLE;
                end else begin
                    h_d = round_out;
                    if (rcnt_q == 3'(HASH_ROUNDS - 1)) state_d = ST_CHECK;
                    else                               rcnt_d  = rcnt_q + 3'd1;
                end
            end
            ST_CHECK: begin
                if (!bus.enable_mining) begin
                    state_d = ST_IDLE;
                end else if (pass || last_try) begin
                    hash_d   = h_q;
                    done_d   = 1'b1;
                    failed_d = !pass;
                    state_d  = ST_DONE;
                end else begin
                    nonce_d = nonce_inc;
                    h_d     = prev_q ^ HASH_W'(nonce_inc);
                    rcnt_d  = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (!bus.enable_mining) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            prev_q   <= '0;
            h_q      <= '0;
            hash_q   <= '0;
            nonce_q  <= '0;
            rcnt_q   <= '0;
            done_q   <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            prev_q   <= prev_d;
            h_q      <= h_d;
            hash_q   <= hash_d;
            nonce_q  <= nonce_d;
            rcnt_q   <= rcnt_d;
            done_q   <= done_d;
            failed_q <= failed_d;
        end
    end

    assign bus.mining_hash   = hash_q;
    assign bus.done_mining   = done_q;
    assign bus.mining_failed = failed_q;
    assign bus.nonce         = nonce_q;
    assign bus.busy          = (state_q == ST_ROUND) || (state_q == ST_CHECK);
endmodule

// File: tb/tb_hash_miner.sv
// Scoreboard bench for hash_miner: three instances (difficulty 0, 1, 8/2-bit nonce) against a plain-arithmetic model.
module tb_hash_miner;
    typedef struct packed {
        logic [7:0]  hash;
        logic [7:0]  nonce;
        logic        failed;
        logic [31:0] lat;
    } exp_t;

`ifdef MINER_ATTEMPT_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic        en [3];
    logic        lr [3];
    logic        lp [3];
    logic [47:0] bd [3];
    logic [7:0]  ph [3];

    logic        done_s [3];
    logic        fail_s [3];
    logic        busy_s [3];
    logic [7:0]  hash_s [3];
    logic [7:0]  nonce_s [3];

    logic        done_p [3];
    int          ecnt [3];
    logic [47:0] st_data [3];
    logic [7:0]  st_prev [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    hash_miner_if #(.NONCE_W(8)) if0 ();
    hash_miner_if #(.NONCE_W(8)) if1 ();
    hash_miner_if #(.NONCE_W(2)) if2 ();

    hash_miner #(.DIFFICULTY(0), .NONCE_W(8), .MAX_ATTEMPTS(16)) u0 (.clock(clock), .resetn(resetn), .bus(if0));
    hash_miner #(.DIFFICULTY(1), .NONCE_W(8), .MAX_ATTEMPTS(16)) u1 (.clock(clock), .resetn(resetn), .bus(if1));
    hash_miner #(.DIFFICULTY(8), .NONCE_W(2), .MAX_ATTEMPTS(2))  u2 (.clock(clock), .resetn(resetn), .bus(if2));

    assign if0.enable_mining = en[0];  assign if1.enable_mining = en[1];  assign if2.enable_mining = en[2];
    assign if0.load_registers = lr[0]; assign if1.load_registers = lr[1]; assign if2.load_registers = lr[2];
    assign if0.load_previous_hash = lp[0]; assign if1.load_previous_hash = lp[1]; assign if2.load_previous_hash = lp[2];
    assign if0.block_data = bd[0];     assign if1.block_data = bd[1];     assign if2.block_data = bd[2];
    assign if0.prev_hash_in = ph[0];   assign if1.prev_hash_in = ph[1];   assign if2.prev_hash_in = ph[2];

    assign done_s[0] = if0.done_mining;   assign done_s[1] = if1.done_mining;   assign done_s[2] = if2.done_mining;
    assign fail_s[0] = if0.mining_failed; assign fail_s[1] = if1.mining_failed; assign fail_s[2] = if2.mining_failed;
    assign busy_s[0] = if0.busy;          assign busy_s[1] = if1.busy;          assign busy_s[2] = if2.busy;
    assign hash_s[0] = if0.mining_hash;   assign hash_s[1] = if1.mining_hash;   assign hash_s[2] = if2.mining_hash;
    assign nonce_s[0] = if0.nonce;        assign nonce_s[1] = if1.nonce;        assign nonce_s[2] = 8'(if2.nonce);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: try nonces in order, hash with plain integer arithmetic.
    function automatic exp_t model(input int i, input logic [47:0] d, input logic [7:0] p);
        int diff, nw, maxa, h, b;
        bit ok;
        exp_t e;
        e = '0;
        case (i)
            0:       begin diff = 0; nw = 8; maxa = 16; end
            1:       begin diff = 1; nw = 8; maxa = 16; end
            default: begin diff = 8; nw = 2; maxa = 2;  end
        endcase
        for (int k = 0; k < (1 << nw); k++) begin
            h = int'(p) ^ k;
            for (int r = 0; r < 6; r++) begin
                b = int'((d >> (40 - 8 * r)) & 48'hFF);
                h = (((h * 8) % 256) + (h / 32)) ^ b;
                h = (h + 90) % 256;
            end
            ok = (diff == 0) || ((h >> (8 - diff)) == 0);
            if (ok || k == (1 << nw) - 1 || (LIM && k == maxa - 1)) begin
                e.hash   = 8'(h);
                e.nonce  = 8'(k);
                e.failed = !ok;
                e.lat    = 32'(8 + 7 * k);
                return e;
            end
        end
        return e;
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) ecnt[i] <= en[i] ? ecnt[i] + 1 : 0;
    end

    // Monitor: every rising done_mining consumes one expected result.
    always @(negedge clock) begin
        exp_t e;
        bit   got;
        for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1 && done_p[i] !== 1'b1) begin
                got = 1'b0;
                e   = '0;
                case (i)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                if (!got) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done dut%0d: done rose with no search pending", i);
                end else begin
                    chk($sformatf("sb_hash dut%0d", i),    32'(hash_s[i]),  32'(e.hash));
                    chk($sformatf("sb_nonce dut%0d", i),   32'(nonce_s[i]), 32'(e.nonce));
                    chk($sformatf("sb_failed dut%0d", i),  32'(fail_s[i]),  32'(e.failed));
                    chk($sformatf("sb_latency dut%0d", i), 32'(ecnt[i]),    e.lat);
                end
            end
            done_p[i] <= done_s[i];
        end
    end

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic search(input int i, input bit ld_d, input bit ld_p, input bit same,
                          input logic [47:0] d, input logic [7:0] p, input int hold);
        exp_t e;
        bit   seen;
        @(negedge clock);
        bd[i] = d; ph[i] = p; lr[i] = ld_d; lp[i] = ld_p;
        if (ld_d) st_data[i] = d;
        if (ld_p) st_prev[i] = p;
        if (!same) begin
            @(negedge clock);
            lr[i] = 1'b0; lp[i] = 1'b0;
        end
        en[i] = 1'b1;
        e = model(i, st_data[i], st_prev[i]);
        push_exp(i, e);
        @(negedge clock);
        lr[i] = 1'b0; lp[i] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2500 && !seen; c++) begin
            if (done_s[i] === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: no done_mining within cycle budget", i);
        end else begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clock);
                chk($sformatf("hold_done dut%0d", i), 32'(done_s[i]),  32'd1);
                chk($sformatf("hold_hash dut%0d", i), 32'(hash_s[i]),  32'(e.hash));
                chk($sformatf("hold_busy dut%0d", i), 32'(busy_s[i]),  32'd0);
            end
        end
        en[i] = 1'b0;
        @(negedge clock);
        chk($sformatf("release_done dut%0d", i), 32'(done_s[i]), 32'd0);
        chk($sformatf("release_hash dut%0d", i), 32'(hash_s[i]), 32'(e.hash));
        chk($sformatf("release_busy dut%0d", i), 32'(busy_s[i]), 32'd0);
    endtask

    task automatic check_zero(input int i, input string tag);
        chk($sformatf("%s_hash dut%0d", tag, i),   32'(hash_s[i]),  32'd0);
        chk($sformatf("%s_nonce dut%0d", tag, i),  32'(nonce_s[i]), 32'd0);
        chk($sformatf("%s_done dut%0d", tag, i),   32'(done_s[i]),  32'd0);
        chk($sformatf("%s_failed dut%0d", tag, i), 32'(fail_s[i]),  32'd0);
        chk($sformatf("%s_busy dut%0d", tag, i),   32'(busy_s[i]),  32'd0);
    endtask

    initial begin
        logic [63:0] r64;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; lr[i] = 1'b0; lp[i] = 1'b0; bd[i] = '0; ph[i] = '0;
            st_data[i] = '0; st_prev[i] = '0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        resetn = 1'b1;

        search(0, 1'b1, 1'b1, 1'b1, 48'h0, 8'h00, 3);
        chk("dut0_zero_hash", 32'(hash_s[0]), 32'hF2);

        search(1, 1'b1, 1'b1, 1'b1, 48'h0, 8'h00, 20);
        chk("dut1_zero_hash", 32'(hash_s[1]), 32'h4E);
        chk("dut1_zero_nonce", 32'(nonce_s[1]), 32'd1);

        // Abort mid-round; a load pulsed while busy must not stick.
        @(negedge clock);
        en[1] = 1'b1;
        repeat (2) @(negedge clock);
        lr[1] = 1'b1; bd[1] = 48'hDEAD_BEEF_CAFE; lp[1] = 1'b1; ph[1] = 8'h77;
        @(negedge clock);
        lr[1] = 1'b0; lp[1] = 1'b0;
        chk("abort_busy_before", 32'(busy_s[1]), 32'd1);
        @(negedge clock);
        en[1] = 1'b0;
        @(negedge clock);
        chk("abort_busy_after", 32'(busy_s[1]), 32'd0);
        chk("abort_no_done", 32'(done_s[1]), 32'd0);
        chk("abort_hash_kept", 32'(hash_s[1]), 32'h4E);
        search(1, 1'b0, 1'b0, 1'b1, 48'h0, 8'h00, 1);
        chk("abort_data_unchanged", 32'(hash_s[1]), 32'h4E);

        search(2, 1'b1, 1'b1, 1'b0, 48'h0, 8'h00, 2);
        chk("dut2_exhaust_failed", 32'(fail_s[2]), 32'd1);

        // Synchronous reset in the middle of a search.
        @(negedge clock);
        bd[0] = 48'h1234_5678_9ABC; lr[0] = 1'b1; en[0] = 1'b1;
        @(negedge clock);
        lr[0] = 1'b0;
        repeat (2) @(negedge clock);
        chk("midreset_busy_before", 32'(busy_s[0]), 32'd1);
        resetn = 1'b0; en[0] = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) check_zero(i, "midreset");
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin st_data[i] = '0; st_prev[i] = '0; end
        search(0, 1'b0, 1'b0, 1'b1, 48'h0, 8'h00, 1);
        chk("post_reset_hash", 32'(hash_s[0]), 32'hF2);

        for (int n = 0; n < 18; n++) begin
            int dut;
            dut = $urandom_range(0, 2);
            r64 = {$urandom(), $urandom()};
            search(dut, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   r64[47:0], 8'($urandom_range(0, 255)), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clock);
        chk("sb_drain dut0", 32'(q0.size()), 32'd0);
        chk("sb_drain dut1", 32'(q1.size()), 32'd0);
        chk("sb_drain dut2", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
